// File: rtl/sum_pkg.sv
// sum_pkg: shared adder-select constants and default sizing for the sum datapath.
package sum_pkg;
   localparam logic ADD_INC = 1'b0;
   localparam logic ADD_ACC = 1'b1;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_LIMIT = 10;
   localparam int DEF_FIFO_DEPTH = 4;
endpackage

// File: rtl/sum_fifo.sv
// sum_fifo: power-of-two result FIFO; a push into a full FIFO is accepted only alongside a pop.
module sum_fifo
   import sum_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0] wr_q, rd_q, wr_d, rd_d;
   logic do_pop, do_push;
   // pointers carry one extra lap bit so full and empty are distinguishable
   assign empty_o = wr_q == rd_q;
   assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign data_o = mem_q[rd_q[AW-1:0]];
   always_comb begin
      wr_d = do_push ? wr_q + 1'b1 : wr_q;
      rd_d = do_pop ? rd_q + 1'b1 : rd_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
   end
endmodule

// File: rtl/sum_datapath.sv
// sum_datapath: n/sum accumulator datapath with output buffer and result FIFO.
// Define SUM_DP_PROTOCOL_CHECK_EN to enable the sticky illegal-control-word checker.
module sum_datapath
   import sum_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int LIMIT = DEF_LIMIT,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             nSel,
   input  logic             sumSel,
   input  logic             adderMuxSel,
   input  logic             nEn,
   input  logic             sumEn,
   input  logic             outBuf,
   output logic             nlt10,
   output logic [WIDTH-1:0] out_buf_data,
   output logic [WIDTH-1:0] res_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_ovf,
   output logic             proto_err
);
   localparam logic [31:0] LIM = LIMIT;
   logic [WIDTH-1:0] n_q, sum_q, ob_q, add, n_d, sum_d;
   logic ovf_q, push, pop, full, empty;
   always_comb begin
      add = (adderMuxSel == ADD_ACC) ? sum_q + n_q : n_q + 1'b1;
      n_d = nSel ? add : '0;
      sum_d = sumSel ? add : '0;
   end
   assign push = outBuf & sumEn;
   assign pop = res_valid & res_ready;
   assign nlt10 = 32'(n_q) < LIM;
   assign out_buf_data = ob_q;
   assign res_valid = ~empty;
   assign res_ovf = ovf_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         n_q <= '0;
         sum_q <= '0;
         ob_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (nEn) n_q <= n_d;
         if (sumEn) sum_q <= sum_d;
         if (outBuf) ob_q <= sum_q;
         if (push & full & ~pop) ovf_q <= 1'b1;
      end
   end
   sum_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .data_i(sum_d),
      .data_o(res_data), .full_o(full), .empty_o(empty)
   );
`ifdef SUM_DP_PROTOCOL_CHECK_EN
   logic proto_q;
   always_ff @(posedge clk) begin
      if (rst) proto_q <= 1'b0;
      else if ((nEn & sumEn) | (nEn & (adderMuxSel == ADD_ACC)) | (sumEn & (adderMuxSel == ADD_INC)))
         proto_q <= 1'b1;
   end
   assign proto_err = proto_q;
`else
   assign proto_err = 1'b0;
`endif
endmodule
